rtc_bus_arbiter: RTL

- Shares the single RTC register-access engine among three requesters:
  - the power-up/clear sequencer (init);
  - the user time-setting path (write);
  - the periodic display read path (read).
- Grants one requester per transaction with fixed priority, init > write > read.
- Latches the winner's address and data, issues one start pulse to the bus engine, waits for done, then returns a one-cycle ack and any read data.
- Sits between the mode logic and the RTC bus driver.

---
 rtl/rtc_bus_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_arbiter.sv
// Fixed-priority arbiter (init > write > read) sharing one RTC bus engine.
// Optional watchdog abort in WAIT is enabled with `define RTC_ARB_WDOG_EN.
module rtc_bus_arbiter #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 8,
  parameter logic [11:0] TIMEOUT = 12'h0FF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_ini,
  input  logic [AW-1:0] ini_addr,
  input  logic [DW-1:0] ini_data,
  input  logic          req_esc,
  input  logic [AW-1:0] esc_addr,
  input  logic [DW-1:0] esc_data,
  input  logic          req_lec,
  input  logic [AW-1:0] lec_addr,
  output logic          ack_ini,
  output logic          ack_esc,
  output logic          ack_lec,
  output logic [DW-1:0] rd_data,
  output logic [2:0]    grant,
  output logic          busy,
  output logic          txn_start,
  output logic          txn_we,
  output logic [AW-1:0] txn_addr,
  output logic [DW-1:0] txn_wdata,
  input  logic [DW-1:0] txn_rdata,
  input  logic          txn_done,
  output logic          err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          start_q, start_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rd_q, rd_d;

`ifdef RTC_ARB_WDOG_EN
  logic [11:0] wdog_q, wdog_d;
  logic        err_q, err_d;
  logic [12:0] wdog_inc;
  logic        wdog_hit;

  // Extra bit keeps the compare correct even when TIMEOUT is 12'hFFF.
  assign wdog_inc = {1'b0, wdog_q} + 13'd1;
  assign wdog_hit = (wdog_inc >= {1'b0, TIMEOUT});
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    busy_d  = busy_q;
    start_d = start_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
`ifdef RTC_ARB_WDOG_EN
    wdog_d  = wdog_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_ini) begin
          grant_d = 3'b100;
          we_d    = 1'b1;
          addr_d  = ini_addr;
          wdata_d = ini_data;
        end else if (req_esc) begin
          grant_d = 3'b010;
          we_d    = 1'b1;
          addr_d  = esc_addr;
          wdata_d = esc_data;
        end else if (req_lec) begin
          grant_d = 3'b001;
          we_d    = 1'b0;
          addr_d  = lec_addr;
          wdata_d = '0;
        end
        if (req_ini || req_esc || req_lec) begin
          busy_d  = 1'b1;
          start_d = 1'b1;
          state_d = StIssue;
        end
      end

      // txn_done is deliberately not looked at here.
      StIssue: begin
        start_d = 1'b0;
        state_d = StWait;
`ifdef RTC_ARB_WDOG_EN
        wdog_d  = '0;
`endif
      end

      StWait: begin
        if (txn_done) begin
          state_d = StAck;
          ack_d   = grant_q;
          if (grant_q[0]) begin
            rd_d = txn_rdata;
          end
        end
`ifdef RTC_ARB_WDOG_EN
        else if (wdog_hit) begin
          // Abort: ack the owner so it is not stuck, leave rd_data alone.
          state_d = StAck;
          ack_d   = grant_q;
          err_d   = 1'b1;
        end else begin
          wdog_d = wdog_inc[11:0];
        end
`endif
      end

      StAck: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
    end
  end

`ifdef RTC_ARB_WDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign grant     = grant_q;
  assign ack_ini   = ack_q[2];
  assign ack_esc   = ack_q[1];
  assign ack_lec   = ack_q[0];
  assign busy      = busy_q;
  assign txn_start = start_q;
  assign txn_we    = we_q;
  assign txn_addr  = addr_q;
  assign txn_wdata = wdata_q;
  assign rd_data   = rd_q;

endmodule
